execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 5-stage RV32 pipeline: ALU, branch-condition evaluation, PC+imm target, operand forwarding, and the EX/MEM pipeline register.
- Its registered outputs drive the MEM stage's inputs directly: control bits, rd, funct3/7, jal/jalr, zero, write data, ALU result, PC+imm, PC.
- Contains an iterative multicycle multiplier (RV32M MUL*) and optional divider; it stalls upstream stages while busy.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MD_STEPS, 32, iterations per multiply/divide; must equal XLEN.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- flush  in  1  from MEM PCSrc; squashes the instruction in EX
- ctl_memtoreg_in, ctl_regwrite_in, ctl_memread_in, ctl_memwrite_in, ctl_branch_in  in  1 each  ID/EX control
- ctl_alusrc_in  in  1  1 = imm as operand B
- ctl_aluop_in  in  2  00 add, 01 branch, 10 funct-decoded
- jal_in, jalr_in  in  1 each  jump flags
- pc_in, imm_in, rs1_data_in, rs2_data_in  in  32 each  ID/EX data
- rs1_in, rs2_in, rd_in  in  5 each  register indices
- funct7_in  in  7;  funct3_in  in  3
- wb_regwrite, wb_rd, wb_data  in  1/5/32  MEM/WB writeback, used for forwarding
- stall  out  1  holds PC, IF/ID and ID/EX
- ctl_memtoreg_out, ctl_regwrite_out, ctl_memread_out, ctl_memwrite_out, ctl_branch_out, jal_out, jalr_out, zero_out  out  1 each  EX/MEM register
- rd_out  out  5;  funct7_out  out  7;  funct3_out  out  3
- write_data_out, alu_result_out, pc_imm_out, pc_out  out  32 each

Behaviour:
- Reset is synchronous and active-high on clk: all outputs 0, FSM to IDLE, counter 0.
- Forwarding, per operand: if EX/MEM regwrite, rd_out!=0 and rd_out==rs, use alu_result_out; else if wb_regwrite, wb_rd!=0 and wb_rd==rs, use wb_data; else the register data. EX/MEM takes priority.
- Operand B is imm when alusrc=1, else forwarded rs2. write_data_out is always forwarded rs2.
- ALU when aluop=10, by funct3 with funct7[5]: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Shifts use B[4:0].
- aluop=01 (branch): zero_out = condition by funct3: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- jal/jalr: zero_out=0; alu_result_out=A+B, used by MEM as the jalr target. pc_imm_out = pc_in + imm_in, mod 2^32.
- Single-cycle ops: EX/MEM loads every posedge when not stalled; latency 1.
- M-op: aluop=10, alusrc=0, funct7=0000001.
- FSM IDLE: on an M-op (not flushed), latch forwarded A/B and funct3, assert stall combinationally, go BUSY. EX/MEM loads a bubble (all control/jal/jalr/zero 0).
- FSM BUSY: one shift-add (MUL*) or restoring-divide step per cycle, counter 0..MD_STEPS-1. stall=1; bubbles continue.
- FSM DONE: stall=0; EX/MEM loads the result with the instruction's controls; go to IDLE.
- M-op occupancy: MD_STEPS+2 cycles in EX.
- MUL returns the low word; MULH, MULHSU and MULHU return the high word with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. 0x80000000/−1: quotient 0x80000000, remainder 0.
- flush: next edge loads a bubble into EX/MEM and forces the FSM to IDLE, aborting any M-op. stall drops the cycle after flush.
- flush has priority over stall and DONE. Reset has priority over flush.

Optional Feature:
- RV32M_DIV_EN defined: DIV, DIVU, REM, REMU use the iterative divider, with the same latency and corner cases as above.
- RV32M_DIV_EN undefined: those ops complete single-cycle with alu_result_out=0, no stall, and no divider logic is synthesized.

Decomposition:
- Shared package riscv_pkg: ALUOp encodings, funct3 branch and ALU codes, FUNCT7_MULDIV=7'b0000001, FSM state enum (IDLE/BUSY/DONE), XLEN.
- Sub-module muldiv_iter: FSM, counter, operand and accumulator registers; interface start/op/a/b → busy/done/result.

Test Plan:
- Single-cycle ALU: ADD A=5, B=7 → alu_result_out=12 one cycle later; SUB 5−7 → 0xFFFFFFFE.
- Forwarding: back-to-back dependent ADDs, second rs1 = first rd → EX/MEM value used. MEM/WB-only match → wb_data used. rd=0 → never forwarded.
- Branch: BLT rs1=0xFFFFFFFF, rs2=1 → zero_out=1; BLTU same operands → 0; pc_in=0x100, imm=0x20 → pc_imm_out=0x120.
- MUL 0x10000 × 0x10000: stall for 33 cycles, bubbles in EX/MEM, then alu_result_out=0 with regwrite=1. MULHU on the same operands → 1.
- Flush during BUSY at iteration 10 → next-cycle bubble, stall=0, FSM IDLE, no regwrite issued.
- With RV32M_DIV_EN: DIV 7/0 → 0xFFFFFFFF; REM −7/2 → −1; DIV 0x80000000/−1 → 0x80000000. Without it: DIV → 0 with no stall.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 encodings for the execute stage: ALUOp codes, funct3 codes,
// the RV32M funct7 marker and the multiply/divide FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: one shift-add multiply step per cycle, plus a
// restoring divider when RV32M_DIV_EN is defined. Operates on magnitudes, fixes sign at the end.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// BUSY  | one iteration per cycle, count 0..MD_STEPS-1
// DONE  | result valid for one cycle
module muldiv_iter
  import riscv_pkg::*;
#(
  parameter int MD_STEPS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(MD_STEPS);

  md_state_e         state, state_next;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   acc_hi, acc_lo, mcand;
  logic              neg_q;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   hi_step, lo_step;
  logic [2*XLEN-1:0] prod;
`ifdef RV32M_DIV_EN
  logic              neg_r, b_zero;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (count == CW'(MD_STEPS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  always_comb begin
    a_neg = a[XLEN-1] & ((op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM));
    b_neg = b[XLEN-1] & ((op == F3_MULH) || (op == F3_DIV) || (op == F3_REM));
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // acc_hi:acc_lo is the product (multiplier shifts out of acc_lo) or remainder:quotient
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    hi_step = mul_sum[XLEN:1];
    lo_step = {mul_sum[0], acc_lo[XLEN-1:1]};
`ifdef RV32M_DIV_EN
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    if (op_q[2]) begin
      hi_step = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_step = {acc_lo[XLEN-2:0], ~div_diff[XLEN+1]};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      op_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      neg_q  <= 1'b0;
`ifdef RV32M_DIV_EN
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
`endif
    end else if (state == IDLE && start && !abort) begin
      count  <= '0;
      op_q   <= op;
      acc_hi <= '0;
      acc_lo <= op[2] ? a_mag : b_mag;
      mcand  <= op[2] ? b_mag : a_mag;
      neg_q  <= a_neg ^ b_neg;
`ifdef RV32M_DIV_EN
      neg_r  <= a_neg;
      b_zero <= (b == '0);
`endif
    end else if (state == BUSY) begin
      count  <= count + 1'b1;
      acc_hi <= hi_step;
      acc_lo <= lo_step;
    end
  end

  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_q) prod = -prod;
    case (op_q)
      F3_MUL:                       result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
`ifdef RV32M_DIV_EN
      // divide by zero keeps the all-ones quotient regardless of dividend sign
      F3_DIV, F3_DIVU:              result = (neg_q && !b_zero) ? -acc_lo : acc_lo;
      F3_REM, F3_REMU:              result = neg_r ? -acc_hi : acc_hi;
`endif
      default:                      result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32 EX stage: forwarding, ALU, branch compare, PC+imm and the EX/MEM register.
// RV32M_DIV_EN adds the iterative divider; without it DIV/REM ops return 0 in one cycle.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int MD_STEPS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            ctl_memtoreg_in,
  input  logic            ctl_regwrite_in,
  input  logic            ctl_memread_in,
  input  logic            ctl_memwrite_in,
  input  logic            ctl_branch_in,
  input  logic            ctl_alusrc_in,
  input  logic [1:0]      ctl_aluop_in,
  input  logic            jal_in,
  input  logic            jalr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [6:0]      funct7_in,
  input  logic [2:0]      funct3_in,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            ctl_memtoreg_out,
  output logic            ctl_regwrite_out,
  output logic            ctl_memread_out,
  output logic            ctl_memwrite_out,
  output logic            ctl_branch_out,
  output logic            jal_out,
  output logic            jalr_out,
  output logic            zero_out,
  output logic [4:0]      rd_out,
  output logic [6:0]      funct7_out,
  output logic [2:0]      funct3_out,
  output logic [XLEN-1:0] write_data_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] pc_imm_out,
  output logic [XLEN-1:0] pc_out
);

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, res_next, md_result;
  logic            branch_cond, is_md, iter_op, md_start, md_busy, md_done, bubble;

  function automatic logic [XLEN-1:0] forward(input logic [4:0] rs, input logic [XLEN-1:0] rf,
                                              input logic exm_we, input logic [4:0] exm_rd,
                                              input logic [XLEN-1:0] exm_val);
    if (exm_we && exm_rd != '0 && exm_rd == rs)           return exm_val;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == rs)   return wb_data;
    else                                                  return rf;
  endfunction

  always_comb begin
    op_a  = forward(rs1_in, rs1_data_in, ctl_regwrite_out, rd_out, alu_result_out);
    fwd_b = forward(rs2_in, rs2_data_in, ctl_regwrite_out, rd_out, alu_result_out);
    op_b  = ctl_alusrc_in ? imm_in : fwd_b;
  end

  always_comb begin
    alu_res = op_a + op_b;
    case (ctl_aluop_in)
      ALUOP_BRANCH: alu_res = op_a - op_b;
      ALUOP_FUNCT: begin
        case (funct3_in)
          F3_ADD:  alu_res = (funct7_in[5] && !ctl_alusrc_in) ? op_a - op_b : op_a + op_b;
          F3_SLL:  alu_res = op_a << op_b[4:0];
          F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
          F3_XOR:  alu_res = op_a ^ op_b;
          F3_SR: begin
            if (funct7_in[5]) alu_res = $signed(op_a) >>> op_b[4:0];
            else              alu_res = op_a >> op_b[4:0];
          end
          F3_OR:   alu_res = op_a | op_b;
          F3_AND:  alu_res = op_a & op_b;
          default: alu_res = op_a + op_b;
        endcase
      end
      default: alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    case (funct3_in)
      F3_BEQ:  branch_cond = (op_a == op_b);
      F3_BNE:  branch_cond = (op_a != op_b);
      F3_BLT:  branch_cond = ($signed(op_a) <  $signed(op_b));
      F3_BGE:  branch_cond = ($signed(op_a) >= $signed(op_b));
      F3_BLTU: branch_cond = (op_a <  op_b);
      F3_BGEU: branch_cond = (op_a >= op_b);
      default: branch_cond = 1'b0;
    endcase
  end

  assign is_md = (ctl_aluop_in == ALUOP_FUNCT) && !ctl_alusrc_in && (funct7_in == FUNCT7_MULDIV);
`ifdef RV32M_DIV_EN
  assign iter_op = is_md;
`else
  assign iter_op = is_md && !funct3_in[2];
`endif

  // start is only taken in IDLE; the instruction stays in ID/EX until DONE
  assign md_start = iter_op && !md_busy && !md_done && !flush;
  assign stall    = md_start || md_busy;
  assign bubble   = flush || stall;

  muldiv_iter #(.MD_STEPS(MD_STEPS)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .abort  (flush),
    .op     (funct3_in),
    .a      (op_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    if (is_md)                res_next = iter_op ? md_result : '0;
    else if (jal_in || jalr_in) res_next = op_a + op_b;
    else                      res_next = alu_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_memtoreg_out <= 1'b0;
      ctl_regwrite_out <= 1'b0;
      ctl_memread_out  <= 1'b0;
      ctl_memwrite_out <= 1'b0;
      ctl_branch_out   <= 1'b0;
      jal_out          <= 1'b0;
      jalr_out         <= 1'b0;
      zero_out         <= 1'b0;
      rd_out           <= '0;
      funct7_out       <= '0;
      funct3_out       <= '0;
      write_data_out   <= '0;
      alu_result_out   <= '0;
      pc_imm_out       <= '0;
      pc_out           <= '0;
    end else begin
      ctl_memtoreg_out <= !bubble && ctl_memtoreg_in;
      ctl_regwrite_out <= !bubble && ctl_regwrite_in;
      ctl_memread_out  <= !bubble && ctl_memread_in;
      ctl_memwrite_out <= !bubble && ctl_memwrite_in;
      ctl_branch_out   <= !bubble && ctl_branch_in;
      jal_out          <= !bubble && jal_in;
      jalr_out         <= !bubble && jalr_in;
      zero_out         <= !bubble && (ctl_aluop_in == ALUOP_BRANCH) && !jal_in && !jalr_in
                          && branch_cond;
      rd_out           <= rd_in;
      funct7_out       <= funct7_in;
      funct3_out       <= funct3_in;
      write_data_out   <= fwd_b;
      alu_result_out   <= res_next;
      pc_imm_out       <= pc_in + imm_in;
      pc_out           <= pc_in;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU/branch vector table, forwarding,
// multicycle MUL/DIV, flush abort. Compile with +define+RV32M_DIV_EN for the divider cases.
module tb_execute_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        ctl_memtoreg_in, ctl_regwrite_in, ctl_memread_in, ctl_memwrite_in, ctl_branch_in;
  logic        ctl_alusrc_in;
  logic [1:0]  ctl_aluop_in;
  logic        jal_in, jalr_in;
  logic [31:0] pc_in, imm_in, rs1_data_in, rs2_data_in;
  logic [4:0]  rs1_in, rs2_in, rd_in;
  logic [6:0]  funct7_in;
  logic [2:0]  funct3_in;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        ctl_memtoreg_out, ctl_regwrite_out, ctl_memread_out, ctl_memwrite_out;
  logic        ctl_branch_out, jal_out, jalr_out, zero_out;
  logic [4:0]  rd_out;
  logic [6:0]  funct7_out;
  logic [2:0]  funct3_out;
  logic [31:0] write_data_out, alu_result_out, pc_imm_out, pc_out;

  execute_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ctl_memtoreg_in(ctl_memtoreg_in), .ctl_regwrite_in(ctl_regwrite_in),
    .ctl_memread_in(ctl_memread_in), .ctl_memwrite_in(ctl_memwrite_in),
    .ctl_branch_in(ctl_branch_in), .ctl_alusrc_in(ctl_alusrc_in), .ctl_aluop_in(ctl_aluop_in),
    .jal_in(jal_in), .jalr_in(jalr_in), .pc_in(pc_in), .imm_in(imm_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .funct7_in(funct7_in), .funct3_in(funct3_in),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .ctl_memtoreg_out(ctl_memtoreg_out), .ctl_regwrite_out(ctl_regwrite_out),
    .ctl_memread_out(ctl_memread_out), .ctl_memwrite_out(ctl_memwrite_out),
    .ctl_branch_out(ctl_branch_out), .jal_out(jal_out), .jalr_out(jalr_out), .zero_out(zero_out),
    .rd_out(rd_out), .funct7_out(funct7_out), .funct3_out(funct3_out),
    .write_data_out(write_data_out), .alu_result_out(alu_result_out),
    .pc_imm_out(pc_imm_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic        alusrc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        jal, jalr, regwrite;
    logic [31:0] a, b, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        chk_res;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string n, input logic [1:0] aluop, input logic alusrc,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm, input logic chk,
                              input logic [31:0] er, input logic ez);
    vec_t v;
    v.name = n; v.aluop = aluop; v.alusrc = alusrc; v.f3 = f3; v.f7 = f7;
    v.jal = 1'b0; v.jalr = 1'b0; v.regwrite = 1'b1;
    v.a = a; v.b = b; v.imm = imm; v.pc = 32'h100;
    v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = 5'd10;
    v.chk_res = chk; v.exp_res = er; v.exp_zero = ez;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ctl_aluop_in = v.aluop; ctl_alusrc_in = v.alusrc; funct3_in = v.f3; funct7_in = v.f7;
    jal_in = v.jal; jalr_in = v.jalr; ctl_regwrite_in = v.regwrite;
    ctl_branch_in = (v.aluop == ALUOP_BRANCH);
    ctl_memtoreg_in = 1'b0; ctl_memread_in = 1'b0; ctl_memwrite_in = 1'b0;
    rs1_data_in = v.a; rs2_data_in = v.b; imm_in = v.imm; pc_in = v.pc;
    rs1_in = v.rs1; rs2_in = v.rs2; rd_in = v.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input string n, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    int   cyc;
    bit   bubbles_ok;
    v = mk(n, ALUOP_FUNCT, 1'b0, f3, FUNCT7_MULDIV, a, b, 32'h0, 1'b1, exp, 1'b0);
    v.rd = 5'd9;
    drive(v);
    #1;
    cyc = 0;
    bubbles_ok = 1'b1;
    while (stall && cyc < 100) begin
      cyc++;
      tick();
      if (ctl_regwrite_out !== 1'b0) bubbles_ok = 1'b0;
    end
    chk({n, " stall_cycles"}, cyc, 33);
    chk({n, " bubbles"}, {31'b0, bubbles_ok}, 1);
    tick();
    chk({n, " result"}, alu_result_out, exp);
    chk({n, " regwrite"}, ctl_regwrite_out, 1);
    chk({n, " rd"}, rd_out, 9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v, nop;
    nop = mk("nop", ALUOP_ADD, 1'b0, F3_ADD, 7'h0, 0, 0, 0, 1'b0, 0, 1'b0);
    nop.regwrite = 1'b0;

    vecs.push_back(mk("add",  ALUOP_FUNCT, 0, F3_ADD,  7'h00, 5, 7, 0, 1, 32'd12, 0));
    vecs.push_back(mk("sub",  ALUOP_FUNCT, 0, F3_ADD,  7'h20, 5, 7, 0, 1, 32'hFFFFFFFE, 0));
    vecs.push_back(mk("sll",  ALUOP_FUNCT, 0, F3_SLL,  7'h00, 1, 32'h24, 0, 1, 32'h10, 0));
    vecs.push_back(mk("slt",  ALUOP_FUNCT, 0, F3_SLT,  7'h00, 32'hFFFFFFFF, 1, 0, 1, 1, 0));
    vecs.push_back(mk("sltu", ALUOP_FUNCT, 0, F3_SLTU, 7'h00, 32'hFFFFFFFF, 1, 0, 1, 0, 0));
    vecs.push_back(mk("xor",  ALUOP_FUNCT, 0, F3_XOR,  7'h00, 32'hF0F0, 32'hFF00, 0, 1, 32'h0FF0, 0));
    vecs.push_back(mk("srl",  ALUOP_FUNCT, 0, F3_SR,   7'h00, 32'h80000000, 4, 0, 1, 32'h08000000, 0));
    vecs.push_back(mk("sra",  ALUOP_FUNCT, 0, F3_SR,   7'h20, 32'h80000000, 4, 0, 1, 32'hF8000000, 0));
    vecs.push_back(mk("or",   ALUOP_FUNCT, 0, F3_OR,   7'h00, 32'hF0F0, 32'h0F00, 0, 1, 32'hFFF0, 0));
    vecs.push_back(mk("and",  ALUOP_FUNCT, 0, F3_AND,  7'h00, 32'hF0F0, 32'hFF00, 0, 1, 32'hF000, 0));
    vecs.push_back(mk("addi", ALUOP_FUNCT, 1, F3_ADD,  7'h00, 10, 99, 32'hFFFFFFFD, 1, 7, 0));
    vecs.push_back(mk("ldaddr", ALUOP_ADD, 1, F3_ADD,  7'h00, 32'h100, 0, 32'h20, 1, 32'h120, 0));
    vecs.push_back(mk("beq",  ALUOP_BRANCH, 0, F3_BEQ,  7'h00, 3, 3, 32'h20, 0, 0, 1));
    vecs.push_back(mk("bne",  ALUOP_BRANCH, 0, F3_BNE,  7'h00, 3, 3, 32'h20, 0, 0, 0));
    vecs.push_back(mk("blt",  ALUOP_BRANCH, 0, F3_BLT,  7'h00, 32'hFFFFFFFF, 1, 32'h20, 0, 0, 1));
    vecs.push_back(mk("bltu", ALUOP_BRANCH, 0, F3_BLTU, 7'h00, 32'hFFFFFFFF, 1, 32'h20, 0, 0, 0));
    vecs.push_back(mk("bge",  ALUOP_BRANCH, 0, F3_BGE,  7'h00, 1, 32'hFFFFFFFF, 32'h20, 0, 0, 1));
    vecs.push_back(mk("bgeu", ALUOP_BRANCH, 0, F3_BGEU, 7'h00, 1, 32'hFFFFFFFF, 32'h20, 0, 0, 0));
    v = mk("jal", ALUOP_ADD, 1, F3_ADD, 7'h00, 32'h40, 0, 8, 1, 32'h48, 0);
    v.jal = 1'b1; v.pc = 32'h1000;
    vecs.push_back(v);
    v = mk("jalr", ALUOP_BRANCH, 1, F3_BEQ, 7'h00, 8, 0, 8, 1, 16, 0);
    v.jalr = 1'b1; v.pc = 32'h2000;
    vecs.push_back(v);

    reset = 1'b1; flush = 1'b0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    drive(vecs[0]);
    tick(); tick();
    chk("reset alu_result", alu_result_out, 0);
    chk("reset regwrite", ctl_regwrite_out, 0);
    chk("reset pc_imm", pc_imm_out, 0);
    chk("reset rd", rd_out, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk({vecs[i].name, " stall"}, stall, 0);
      tick();
      if (vecs[i].chk_res) chk({vecs[i].name, " result"}, alu_result_out, vecs[i].exp_res);
      chk({vecs[i].name, " zero"}, zero_out, vecs[i].exp_zero);
      chk({vecs[i].name, " pc_imm"}, pc_imm_out, vecs[i].pc + vecs[i].imm);
      chk({vecs[i].name, " write_data"}, write_data_out, vecs[i].b);
      chk({vecs[i].name, " regwrite"}, ctl_regwrite_out, 1);
    end

    // forwarding: EX/MEM beats MEM/WB, then MEM/WB alone, then x0 never forwarded
    v = mk("fwd1", ALUOP_FUNCT, 0, F3_ADD, 7'h00, 5, 7, 0, 1, 12, 0); v.rd = 5'd5;
    drive(v); tick();
    chk("fwd1 result", alu_result_out, 12);
    v = mk("fwd2", ALUOP_FUNCT, 0, F3_ADD, 7'h00, 100, 100, 0, 1, 24, 0);
    v.rs1 = 5'd5; v.rs2 = 5'd5; v.rd = 5'd8;
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'd999;
    drive(v); tick();
    chk("fwd exmem result", alu_result_out, 24);
    chk("fwd exmem write_data", write_data_out, 12);
    v = mk("fwd3", ALUOP_FUNCT, 0, F3_ADD, 7'h00, 0, 1, 0, 1, 51, 0);
    v.rs1 = 5'd6; v.rd = 5'd7;
    wb_rd = 5'd6; wb_data = 32'd50;
    drive(v); tick();
    chk("fwd memwb result", alu_result_out, 51);
    wb_regwrite = 1'b0;
    v = mk("fwd4", ALUOP_FUNCT, 0, F3_ADD, 7'h00, 3, 4, 0, 1, 7, 0); v.rd = 5'd0;
    drive(v); tick();
    chk("x0 producer result", alu_result_out, 7);
    v = mk("fwd5", ALUOP_FUNCT, 0, F3_ADD, 7'h00, 0, 1, 0, 1, 1, 0); v.rs1 = 5'd0;
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'd77;
    drive(v); tick();
    chk("x0 not forwarded", alu_result_out, 1);
    wb_regwrite = 1'b0;

    // single-cycle flush loads a bubble
    v = mk("flush_add", ALUOP_FUNCT, 0, F3_ADD, 7'h00, 1, 1, 0, 1, 2, 0);
    drive(v); flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_add regwrite", ctl_regwrite_out, 0);

    run_md("mul",    F3_MUL,    32'h10000, 32'h10000, 32'h0);
    run_md("mulhu",  F3_MULHU,  32'h10000, 32'h10000, 32'h1);
    run_md("mul_neg", F3_MUL,   7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_md("mulh",   F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    run_md("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 2, 32'hFFFFFFFF);

    // abort a multiply at iteration 10
    v = mk("mul_flush", ALUOP_FUNCT, 0, F3_MUL, FUNCT7_MULDIV, 3, 4, 0, 1, 12, 0);
    drive(v);
    repeat (11) tick();
    chk("mul_flush busy", stall, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mul_flush bubble", ctl_regwrite_out, 0);
    v = mk("after_flush", ALUOP_FUNCT, 0, F3_ADD, 7'h00, 1, 1, 0, 1, 2, 0); v.rd = 5'd11;
    drive(v);
    #1;
    chk("after_flush stall", stall, 0);
    tick();
    chk("after_flush result", alu_result_out, 2);
    chk("after_flush rd", rd_out, 11);
    run_md("mulhu_again", F3_MULHU, 32'h10000, 32'h10000, 32'h1);

`ifdef RV32M_DIV_EN
    run_md("div_by_zero", F3_DIV,  7, 0, 32'hFFFFFFFF);
    run_md("rem_neg",     F3_REM,  32'hFFFFFFF9, 2, 32'hFFFFFFFF);
    run_md("div_ovf",     F3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_md("divu",        F3_DIVU, 100, 7, 14);
    run_md("remu",        F3_REMU, 100, 7, 2);
    run_md("rem_by_zero", F3_REM,  32'hFFFFFFFB, 0, 32'hFFFFFFFB);
`else
    v = mk("div_off", ALUOP_FUNCT, 0, F3_DIV, FUNCT7_MULDIV, 7, 2, 0, 1, 0, 0);
    drive(v);
    #1;
    chk("div_off stall", stall, 0);
    tick();
    chk("div_off result", alu_result_out, 0);
    chk("div_off regwrite", ctl_regwrite_out, 1);
`endif

    drive(nop);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
